button_event_arbiter: RTL and testbench
=======================================

// Module: button_event_arbiter
// PURPOSE
//   Collects single-cycle press flags from N_BTN button debouncers and queues one pending event per button.
//   Shares a single event output among them with round-robin arbitration and a valid/ready handshake.
//   Sits between the per-button debouncers and the consumer (GPIO/CSR block or soft-reset sequencer).
// PARAMETERS
//   N_BTN   4   number of debounced button inputs (2..16)
//   ID_W    2   width of evt_id_o; must satisfy 2**ID_W >= N_BTN
// PORTS
//   clk           in   1      system clock; all logic on rising edge
//   rst           in   1      asynchronous, active-high reset
//   press_i       in   N_BTN  per-button one-cycle press pulse from debouncers
//   en_mask_i     in   N_BTN  1 = button enabled; masked presses are discarded, no overflow
//   evt_valid_o   out  1      event available (registered)
//   evt_id_o      out  ID_W   index of button for current event (registered)
//   evt_ready_i   in   1      consumer accepts event when evt_valid_o & evt_ready_i
//   pending_o     out  N_BTN  current pending bitmap (registered)
//   overflow_o    out  1      sticky: a press was lost
//   ovf_clr_i     in   1      one-cycle clear of overflow_o (and ovf_cnt_o)
//   ovf_cnt_o     out  8      count of lost presses (see CONFIGURATION)
// BEHAVIOUR
//   Reset: evt_valid_o=0, evt_id_o=0, pending_o=0, overflow_o=0, ovf_cnt_o=0, rr_ptr=N_BTN-1.
//   Reset mid-operation: pending presses and any unaccepted event are discarded.
//   pending[k] set on the edge after press_i[k]&en_mask_i[k]; cleared on the edge when k is granted.
//   Output slot free = !evt_valid_o | evt_ready_i; grant happens only when slot free and pending!=0.
//   Grant: first set pending bit searching rr_ptr+1, rr_ptr+2, ... wrapping modulo N_BTN.
//     On grant: evt_valid_o<=1, evt_id_o<=k, pending[k]<=0, rr_ptr<=k.
//   Slot free with no pending bit: evt_valid_o<=0 and evt_id_o holds.
//   Handshake: evt_id_o stable while evt_valid_o & !evt_ready_i; valid never drops without acceptance.
//   Latency: press_i high at edge t -> pending at t+1 -> evt_valid_o at t+2 (slot free, no competitor).
//   Throughput: one event per cycle while evt_ready_i held high.
//   Masking: clearing en_mask_i[k] does not clear an already-pending bit; it is still delivered.
//   Overflow: press_i[k] enabled while pending[k]=1 and k not granted that cycle -> press dropped, overflow_o<=1.
//   Simultaneous press_i[k] with grant of k: pending[k] stays 1 (new event), not an overflow.
//   Simultaneous overflow and ovf_clr_i: set wins (overflow_o=1, ovf_cnt_o=1).
//   Multiple overflowing buttons in one cycle: ovf_cnt_o adds popcount; saturates at 8'hFF.
//   An event in the output slot is not pending; a press on that button re-pends normally.
// CONFIGURATION
//   BTN_EVT_OVF_CNT_EN defined: ovf_cnt_o is a saturating 8-bit lost-press counter as above.
//   BTN_EVT_OVF_CNT_EN undefined: counter logic absent; ovf_cnt_o tied to 8'h00; overflow_o unchanged.
// TESTING
//   1 reset, press_i=4'b0100 one cycle, ready=1 -> evt_valid_o high 2 cycles later, evt_id_o=2, one cycle only
//   2 press_i=4'b1111 same cycle, ready=1 -> ids 0,1,2,3 on consecutive cycles; pending_o drains to 0
//   3 ready=0, press btn1 -> valid,id=1 held; press btn1 twice more -> pending[1]=1, overflow_o=1, ovf_cnt_o=1
//   4 en_mask_i=4'b1110, press_i=4'b0001 -> no event, pending_o=0, overflow_o=0
//   5 after grant of id 1, pending 4'b0011 -> next id 0 (wrap via ptr), not id 1 again first
//   6 assert rst while evt_valid_o=1 and pending_o=4'b1010 -> all outputs 0 asynchronously; no events after release

Source files
------------

// File: rtl/button_event_arbiter.sv
// Button event arbiter: queues one pending press per button and hands them out one at a time
// on a single valid/ready event port, choosing between pending buttons round-robin.
// Optional feature: define BTN_EVT_OVF_CNT_EN to build the saturating lost-press counter on
// ovf_cnt_o; when it is undefined the counter is absent and ovf_cnt_o reads 8'h00.
module button_event_arbiter #(
  parameter int unsigned N_BTN = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] press_i,
  input  logic [N_BTN-1:0] en_mask_i,
  output logic             evt_valid_o,
  output logic [ID_W-1:0]  evt_id_o,
  input  logic             evt_ready_i,
  output logic [N_BTN-1:0] pending_o,
  output logic             overflow_o,
  input  logic             ovf_clr_i,
  output logic [7:0]       ovf_cnt_o
);

  logic [N_BTN-1:0] pending_q, pending_d;
  logic             evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             overflow_q, overflow_d;

  logic             slot_free;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [N_BTN-1:0] grant_vec;
  logic [N_BTN-1:0] press_en;
  logic [N_BTN-1:0] ovf_vec;

  assign slot_free = !evt_valid_q || evt_ready_i;

  // Round-robin pick: first pending button after rr_ptr, wrapping modulo N_BTN.
  always_comb begin
    int target;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    for (int off = 1; off <= int'(N_BTN); off++) begin
      target = int'(rr_ptr_q) + off;
      if (target >= int'(N_BTN)) target = target - int'(N_BTN);
      for (int k = 0; k < int'(N_BTN); k++) begin
        if (slot_free && !grant_found && pending_q[k] && (k == target)) begin
          grant_found  = 1'b1;
          grant_idx    = ID_W'(k);
          grant_vec[k] = 1'b1;
        end
      end
    end
  end

  // Next-state for pending bitmap, output slot, pointer and sticky overflow.
  always_comb begin
    press_en    = press_i & en_mask_i;
    // A press is lost only if its bit stays pending this cycle; a same-cycle grant frees it.
    ovf_vec     = press_en & pending_q & ~grant_vec;
    pending_d   = (pending_q & ~grant_vec) | press_en;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (slot_free) begin
      evt_valid_d = grant_found;
      if (grant_found) begin
        evt_id_d = grant_idx;
        rr_ptr_d = grant_idx;
      end
    end
    overflow_d = overflow_q;
    if (|ovf_vec) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  // State registers; reset discards pending presses and any unaccepted event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_ptr_q    <= ID_W'(N_BTN - 1);
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef BTN_EVT_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;
  logic [7:0] ovf_pop;
  logic [7:0] cnt_base;
  logic [8:0] cnt_sum;

  // Add the number of buttons that lost a press this cycle, saturating; clear loses to a set.
  always_comb begin
    ovf_pop = '0;
    for (int k = 0; k < int'(N_BTN); k++) begin
      ovf_pop = ovf_pop + {7'b0, ovf_vec[k]};
    end
    cnt_base  = ovf_clr_i ? 8'h00 : ovf_cnt_q;
    cnt_sum   = {1'b0, cnt_base} + {1'b0, ovf_pop};
    ovf_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  // Lost-press counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= 8'h00;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt_o = ovf_cnt_q;
`else
  assign ovf_cnt_o = 8'h00;
`endif

  assign evt_valid_o = evt_valid_q;
  assign evt_id_o    = evt_id_q;
  assign pending_o   = pending_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the event queue.
module tb_button_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] press;
  logic [N-1:0] en_mask;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_ready;
  logic [N-1:0] pending;
  logic         overflow;
  logic         ovf_clr;
  logic [7:0]   ovf_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state.
  bit m_pend [N];
  bit m_valid;
  int m_id;
  int m_ptr;
  bit m_ovf;
  int m_cnt;

  button_event_arbiter #(.N_BTN(N), .ID_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .press_i     (press),
    .en_mask_i   (en_mask),
    .evt_valid_o (evt_valid),
    .evt_id_o    (evt_id),
    .evt_ready_i (evt_ready),
    .pending_o   (pending),
    .overflow_o  (overflow),
    .ovf_clr_i   (ovf_clr),
    .ovf_cnt_o   (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int model_pend_vec();
    int v = 0;
    for (int k = 0; k < N; k++) if (m_pend[k]) v += (1 << k);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_pend[k] = 0;
    m_valid = 0;
    m_id    = 0;
    m_ptr   = N - 1;
    m_ovf   = 0;
    m_cnt   = 0;
  endtask

  // One clock edge of the queue: grant, then pend new presses, then account losses.
  task automatic model_update();
    bit slot_free;
    int g;
    int lost;
    slot_free = !m_valid || evt_ready;
    g = -1;
    if (slot_free) begin
      for (int j = 1; j <= N; j++) begin
        if (g < 0 && m_pend[(m_ptr + j) % N]) g = (m_ptr + j) % N;
      end
    end
    lost = 0;
    for (int k = 0; k < N; k++) begin
      bit pe;
      pe = press[k] && en_mask[k];
      if (k == g) m_pend[k] = pe;
      else if (pe && m_pend[k]) lost++;
      else if (pe) m_pend[k] = 1;
    end
    if (slot_free) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_id  = g;
        m_ptr = g;
      end
    end
    if (lost > 0) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
`ifdef BTN_EVT_OVF_CNT_EN
    if (lost > 0) begin
      m_cnt = (ovf_clr ? 0 : m_cnt) + lost;
      if (m_cnt > 255) m_cnt = 255;
    end else if (ovf_clr) begin
      m_cnt = 0;
    end
`endif
  endtask

  task automatic compare_all(input string pfx);
    check_eq({pfx, "_valid"}, int'(evt_valid), int'(m_valid));
    check_eq({pfx, "_id"}, int'(evt_id), m_id);
    check_eq({pfx, "_pending"}, int'(pending), model_pend_vec());
    check_eq({pfx, "_overflow"}, int'(overflow), int'(m_ovf));
    check_eq({pfx, "_ovf_cnt"}, int'(ovf_cnt), m_cnt);
  endtask

  // Apply inputs for one cycle, advance the model at the edge, compare just after it.
  task automatic step(input logic [N-1:0] p, input logic [N-1:0] m, input logic r,
                      input logic c, input string pfx);
    press     = p;
    en_mask   = m;
    evt_ready = r;
    ovf_clr   = c;
    @(posedge clk);
    model_update();
    #1;
    compare_all(pfx);
  endtask

  // Pulse reset between clock edges.
  task automatic do_reset();
    press   = '0;
    ovf_clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    press     = '0;
    en_mask   = '1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    model_reset();
    #1 compare_all("por");
    #11 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single press, event two edges later, one cycle only.
    step(4'b0100, 4'b1111, 1'b1, 1'b0, "t1a");
    step(4'b0000, 4'b1111, 1'b1, 1'b0, "t1b");
    check_eq("t1_valid", int'(evt_valid), 1);
    check_eq("t1_id", int'(evt_id), 2);
    step(4'b0000, 4'b1111, 1'b1, 1'b0, "t1c");
    check_eq("t1_one_cycle", int'(evt_valid), 0);

    // 2: all buttons at once drain in order 0..3.
    do_reset();
    step(4'b1111, 4'b1111, 1'b1, 1'b0, "t2a");
    for (int i = 0; i < N; i++) begin
      step(4'b0000, 4'b1111, 1'b1, 1'b0, "t2b");
      check_eq("t2_id_order", int'(evt_id), i);
    end
    check_eq("t2_drained", int'(pending), 0);

    // 3: stalled consumer, repeated presses overflow.
    do_reset();
    step(4'b0010, 4'b1111, 1'b0, 1'b0, "t3a");
    step(4'b0000, 4'b1111, 1'b0, 1'b0, "t3b");
    step(4'b0010, 4'b1111, 1'b0, 1'b0, "t3c");
    check_eq("t3_no_ovf_yet", int'(overflow), 0);
    step(4'b0010, 4'b1111, 1'b0, 1'b0, "t3d");
    check_eq("t3_held_id", int'(evt_id), 1);
    check_eq("t3_pend1", int'(pending[1]), 1);
    check_eq("t3_ovf", int'(overflow), 1);
`ifdef BTN_EVT_OVF_CNT_EN
    check_eq("t3_cnt", int'(ovf_cnt), 1);
`else
    check_eq("t3_cnt", int'(ovf_cnt), 0);
`endif
    // Overflow and clear together: set wins.
    step(4'b0010, 4'b1111, 1'b0, 1'b1, "t3e");
    check_eq("t3_set_wins", int'(overflow), 1);
    step(4'b0000, 4'b1111, 1'b0, 1'b1, "t3f");
    check_eq("t3_cleared", int'(overflow), 0);

    // 4: masked press is discarded.
    do_reset();
    step(4'b0001, 4'b1110, 1'b1, 1'b0, "t4a");
    step(4'b0000, 4'b1110, 1'b1, 1'b0, "t4b");
    check_eq("t4_pending", int'(pending), 0);
    check_eq("t4_valid", int'(evt_valid), 0);

    // 5: pointer at 1 makes 0 win over 1.
    do_reset();
    step(4'b0010, 4'b1111, 1'b1, 1'b0, "t5a");
    step(4'b0000, 4'b1111, 1'b1, 1'b0, "t5b");
    step(4'b0011, 4'b1111, 1'b1, 1'b0, "t5c");
    step(4'b0000, 4'b1111, 1'b1, 1'b0, "t5d");
    check_eq("t5_first", int'(evt_id), 0);
    step(4'b0000, 4'b1111, 1'b1, 1'b0, "t5e");
    check_eq("t5_second", int'(evt_id), 1);

    // 6: asynchronous reset with an event held and presses pending.
    do_reset();
    step(4'b0010, 4'b1111, 1'b0, 1'b0, "t6a");
    step(4'b0000, 4'b1111, 1'b0, 1'b0, "t6b");
    step(4'b1010, 4'b1111, 1'b0, 1'b0, "t6c");
    check_eq("t6_pending", int'(pending), 10);
    check_eq("t6_valid", int'(evt_valid), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("t6_async");
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) step(4'b0000, 4'b1111, 1'b1, 1'b0, "t6_quiet");

    // Saturation: stalled consumer with every button hammered.
    do_reset();
    for (int i = 0; i < 70; i++) step(4'b1111, 4'b1111, 1'b0, 1'b0, "sat");

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] p;
      logic [N-1:0] m;
      p = N'($urandom) & N'($urandom);
      m = ($urandom_range(0, 7) == 0) ? N'($urandom) : 4'b1111;
      step(p, m, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
